// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of an asynchronous clock over a
// fixed window of fpga_clk_i cycles and reports the saturated count.
module freq_meter #(
  parameter int GATE_CYCLES = 16000,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 fpga_clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 meas_clk_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 valid_o,
  output logic                 ovf_o,
  output logic                 busy_o
);

  localparam int                   GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_REPORT} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_sync1, r_sync2, r_hist;
  logic                 w_edge, w_gate_last;
  logic [GW-1:0]        r_gate;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_ovf, w_ovf_nxt;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_valid, r_ovf_o;

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= meas_clk_i;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_edge      = r_sync2 & ~r_hist;
  assign w_gate_last = (r_gate == GATE_LAST);

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable_i) w_state_nxt = S_ARM;
      S_ARM:    w_state_nxt = enable_i ? S_GATE : S_IDLE;
      S_GATE: begin
        if (!enable_i)        w_state_nxt = S_IDLE;
        else if (w_gate_last) w_state_nxt = S_REPORT;
      end
      S_REPORT: w_state_nxt = enable_i ? S_ARM : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next count includes this cycle's edge so the final GATE cycle is reported.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (r_state == S_GATE && w_edge) begin
      if (r_cnt == CNT_MAX) w_ovf_nxt = 1'b1;
      else                  w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_gate <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else if (r_state == S_ARM) begin
      r_gate <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else if (r_state == S_GATE) begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
      if (!w_gate_last) r_gate <= r_gate + GW'(1);
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
      r_ovf_o <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == S_REPORT);
      if (w_state_nxt == S_REPORT) begin
        r_count <= w_cnt_nxt;
        r_ovf_o <= w_ovf_nxt;
      end
    end
  end

  assign count_o = r_count;
  assign ovf_o   = r_ovf_o;
  assign valid_o = r_valid;
  assign busy_o  = (r_state != S_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (16-bit and 3-bit counters) share stimulus
// and are checked every cycle against a window-arithmetic reference model.
module tb_freq_meter;
  localparam int G = 64;

  logic        clk = 1'b0;
  logic        rst_n, en, m;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;
  logic        vld_a, ovf_a, busy_a, vld_b, ovf_b, busy_b;

  int n_chk = 0, n_fail = 0;
  int t = 0, st = -1, first_vld = -1;
  logic prev_m = 1'b0;
  bit   rise[$];
  int   exp_cnt_a = 0, exp_cnt_b = 0;
  logic exp_ovf_a = 0, exp_ovf_b = 0, exp_busy, exp_vld;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(G), .CNT_WIDTH(16)) dut_a (
    .fpga_clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .meas_clk_i(m),
    .count_o(cnt_a), .valid_o(vld_a), .ovf_o(ovf_a), .busy_o(busy_a));
  freq_meter #(.GATE_CYCLES(G), .CNT_WIDTH(3)) dut_b (
    .fpga_clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .meas_clk_i(m),
    .count_o(cnt_b), .valid_o(vld_b), .ovf_o(ovf_b), .busy_o(busy_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic chk_all(input logic [31:0] ca, input logic oa, input logic [31:0] cb,
                         input logic ob, input logic v, input logic b);
    chk("count_a", {16'd0, cnt_a}, ca);
    chk("ovf_a", {31'd0, ovf_a}, {31'd0, oa});
    chk("valid_a", {31'd0, vld_a}, {31'd0, v});
    chk("busy_a", {31'd0, busy_a}, {31'd0, b});
    chk("count_b", {29'd0, cnt_b}, cb);
    chk("ovf_b", {31'd0, ovf_b}, {31'd0, ob});
    chk("valid_b", {31'd0, vld_b}, {31'd0, v});
    chk("busy_b", {31'd0, busy_b}, {31'd0, b});
  endtask

  // One fpga_clk_i cycle: check outputs, optionally pulse reset between edges,
  // then drive this cycle's inputs and advance the model.
  // A window opened at cycle s samples meas edges of cycles s..s+G-1,
  // is busy on s+1..s+G+2 and reports on s+G+2.
  task automatic cyc(input logic e, input logic mv, input logic do_rst);
    int n;
    @(posedge clk); #2;
    exp_busy = (st >= 0) && (t >= st + 1) && (t <= st + G + 2);
    exp_vld  = (st >= 0) && (t == st + G + 2);
    if (exp_vld) begin
      n = 0;
      for (int i = st; i < st + G; i++) n += int'(rise[i]);
      exp_cnt_a = (n > 65535) ? 65535 : n;
      exp_ovf_a = (n > 65535);
      exp_cnt_b = (n > 7) ? 7 : n;
      exp_ovf_b = (n > 7);
    end
    chk_all(exp_cnt_a, exp_ovf_a, exp_cnt_b, exp_ovf_b, exp_vld, exp_busy);
    if (vld_a && first_vld < 0) first_vld = t;
    if (do_rst) begin
      rst_n = 1'b0; #1;
      chk_all(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      st = -1; prev_m = 1'b0;
      exp_cnt_a = 0; exp_cnt_b = 0; exp_ovf_a = 0; exp_ovf_b = 0;
    end
    en = e; m = mv;
    rise.push_back(mv & ~prev_m);
    prev_m = mv;
    if (st >= 0 && t >= st + 1 && t <= st + G + 1 && !e) st = -1;
    else if (st >= 0 && t == st + G + 2) st = e ? t : -1;
    else if (st < 0 && e) st = t;
    t++;
  endtask

  function automatic logic div(input int d);
    return ((t % d) < (d / 2));
  endfunction

  initial begin
    int s0, d;
    logic rm;
    rst_n = 1'b0; en = 1'b0; m = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk_all(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    repeat (3) cyc(0, 0, 0);
    // Divide-by-8, enable held: 8 edges per window, period G+2
    s0 = t;
    repeat (3 * (G + 2) + 2) cyc(1, div(8), 0);
    chk("first_valid_latency", first_vld, s0 + G + 2);
    chk("count_div8", {16'd0, cnt_a}, 8);
    repeat (3) cyc(0, div(8), 0);
    // Static meas low then high
    repeat (G + 3) cyc(1, 0, 0);
    repeat (2) cyc(0, 0, 0);
    repeat (G + 3) cyc(1, 1, 0);
    repeat (2) cyc(0, 1, 0);
    // Saturation of the 3-bit counter then recovery on a slow clock
    repeat (G + 2) cyc(1, div(4), 0);
    repeat (G + 3) cyc(1, div(32), 0);
    repeat (2) cyc(0, 0, 0);
    // Abort mid-gate after a result of 8
    repeat (G + 3 + 20) cyc(1, div(8), 0);
    cyc(0, div(8), 0);
    cyc(0, div(8), 0);
    chk("abort_busy", {31'd0, busy_a}, 0);
    chk("abort_keep", {16'd0, cnt_a}, 8);
    // Asynchronous reset mid-gate, then a fresh window
    repeat (30) cyc(1, div(8), 0);
    cyc(1, div(8), 1);
    repeat (G + 4) cyc(1, div(8), 0);
    chk("post_reset_count", {16'd0, cnt_a}, 8);
    // Randomized meas patterns, enable drops and resets
    for (int k = 0; k < 1800; k++) begin
      if (k % 150 == 0) d = int'($urandom_range(2, 24));
      rm = (d > 20) ? 1'($urandom % 2) : div(d);
      cyc(($urandom % 120) != 0, rm, ($urandom % 600) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
